// File: rtl/e_muldiv.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers of the E stage.
// A start op latches its full 64-bit result, then commits it after a fixed busy window.
module e_muldiv #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] e_A,
    input  logic [31:0] e_B,
    input  logic [3:0]  e_MDop,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] e_MDout
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MSUB  = 4'd9
    } md_op_e;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    md_op_e op;
    assign op = md_op_e'(e_MDop);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [63:0]        pend_q, pend_d;
    logic               pend_wr_q, pend_wr_d;

    // ------------------------------------------------------------------
    // Result datapath: every candidate result is formed from the current
    // operands; the FSM picks one at the Start edge.
    // ------------------------------------------------------------------
    logic [63:0] mul_s, mul_u, msub_res;
    logic        a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, den_s, den_u;
    logic [31:0] uq_s, ur_s, q_s, r_s, q_u, r_u;

    always_comb begin
        mul_s    = $signed({{32{e_A[31]}}, e_A}) * $signed({{32{e_B[31]}}, e_B});
        mul_u    = {32'd0, e_A} * {32'd0, e_B};
        msub_res = {hi_q, lo_q} - mul_s;

        // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        a_neg  = e_A[31];
        b_neg  = e_B[31];
        b_zero = (e_B == 32'd0);
        a_mag  = a_neg ? (~e_A + 32'd1) : e_A;
        b_mag  = b_neg ? (~e_B + 32'd1) : e_B;
        den_s  = b_zero ? 32'd1 : b_mag;
        den_u  = b_zero ? 32'd1 : e_B;
        uq_s   = a_mag / den_s;
        ur_s   = a_mag % den_s;
        q_s    = (a_neg ^ b_neg) ? (~uq_s + 32'd1) : uq_s;
        r_s    = a_neg ? (~ur_s + 32'd1) : ur_s;
        q_u    = e_A / den_u;
        r_u    = e_A % den_u;
    end

    // ------------------------------------------------------------------
    // Control: next-state, Start and register updates.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        Start     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                unique case (op)
                    OP_MULT, OP_MULTU, OP_MSUB: begin
                        Start     = 1'b1;
                        state_d   = S_BUSY;
                        cnt_d     = CNT_W'(MUL_CYCLES);
                        pend_wr_d = 1'b1;
                        pend_d    = (op == OP_MULT)  ? mul_s :
                                    (op == OP_MULTU) ? mul_u : msub_res;
                    end
                    OP_DIV, OP_DIVU: begin
                        Start     = 1'b1;
                        state_d   = S_BUSY;
                        cnt_d     = CNT_W'(DIV_CYCLES);
                        // Divide by zero still burns the full window but leaves HI/LO alone.
                        pend_wr_d = !b_zero;
                        pend_d    = (op == OP_DIV) ? {r_s, q_s} : {r_u, q_u};
                    end
                    OP_MTHI: hi_d = e_A;
                    OP_MTLO: lo_d = e_A;
                    default: ;
                endcase
            end
            S_BUSY: begin
                // Requests arriving in this state are deliberately ignored.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign Busy = (state_q == S_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        unique case (op)
            OP_MFHI: e_MDout = hi_q;
            OP_MFLO: e_MDout = lo_q;
            default: e_MDout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_muldiv.sv
// Directed bench for e_muldiv: a cycle-level arithmetic model checked every negedge,
// plus hand-computed literal expectations for each directed scenario.
module tb_e_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] e_A, e_B;
    logic [3:0]  e_MDop;
    logic        Start, Busy;
    logic [31:0] HI, LO, e_MDout;

    int n_chk = 0;
    int n_err = 0;

    e_muldiv #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .e_A     (e_A),
        .e_B     (e_B),
        .e_MDop  (e_MDop),
        .Start   (Start),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO),
        .e_MDout (e_MDout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    logic        m_wr;
    int          m_rem;

    function automatic bit is_start_op(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd4) || (op == 4'd9);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = 0; m_lo = 0; m_pend = 0; m_wr = 0; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0 && m_wr) {m_hi, m_lo} = m_pend;
        end else begin
            longint sa, sb;
            longint unsigned ua, ub;
            sa = longint'($signed(e_A));
            sb = longint'($signed(e_B));
            ua = {32'd0, e_A};
            ub = {32'd0, e_B};
            m_wr = 1;
            case (e_MDop)
                4'd1: begin m_pend = sa * sb; m_rem = 5; end
                4'd2: begin m_pend = ua * ub; m_rem = 5; end
                4'd9: begin m_pend = {m_hi, m_lo} - 64'(sa * sb); m_rem = 5; end
                4'd3: begin
                    m_rem = 10;
                    if (sb == 0) m_wr = 0;
                    else m_pend = {32'(sa % sb), 32'(sa / sb)};
                end
                4'd4: begin
                    m_rem = 10;
                    if (ub == 0) m_wr = 0;
                    else m_pend = {32'(ua % ub), 32'(ua / ub)};
                end
                4'd5: m_hi = e_A;
                4'd6: m_lo = e_A;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        check("cmp_start", Start, (is_start_op(e_MDop) && m_rem == 0));
        check("cmp_busy",  Busy,  m_rem > 0);
        check("cmp_hi",    HI,    m_hi);
        check("cmp_lo",    LO,    m_lo);
        check("cmp_mdout", e_MDout,
              (e_MDop == 4'd7) ? m_hi : (e_MDop == 4'd8) ? m_lo : 32'd0);
    end

    // ---------------- stimulus helpers (called at #1 after a rising edge) ----------------
    task automatic wait_idle(input string name, input int exp_busy);
        int n = 0;
        while (Busy && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check({name, "_busy_cycles"}, n, exp_busy);
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input string name, input int exp_busy);
        e_MDop = op; e_A = a; e_B = b;
        #1 check({name, "_start"}, Start, 1'b1);
        @(posedge clk); #1;
        e_MDop = 4'd0;
        wait_idle(name, exp_busy);
    endtask

    task automatic one_cycle(input logic [3:0] op, input logic [31:0] a);
        e_MDop = op; e_A = a;
        @(posedge clk); #1;
        e_MDop = 4'd0;
    endtask

    task automatic read_md(input logic [3:0] op, input string name, input logic [31:0] exp);
        e_MDop = op;
        #1 check(name, e_MDout, exp);
        @(posedge clk); #1;
        e_MDop = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; e_A = 0; e_B = 0; e_MDop = 0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", Busy, 0);
        reset = 1'b0;

        // mult and back-to-back multu/msub
        start_op(4'd1, 32'hFFFF_FFFE, 32'd3, "mult", 5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);
        start_op(4'd2, 32'hFFFF_FFFF, 32'd2, "multu", 5);
        check("multu_hi", HI, 32'd1);
        check("multu_lo", LO, 32'hFFFF_FFFE);
        start_op(4'd9, 32'd1, 32'd1, "msub", 5);
        check("msub_hi", HI, 32'd1);
        check("msub_lo", LO, 32'hFFFF_FFFD);

        // divides
        start_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div", 10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);
        start_op(4'd4, 32'hFFFF_FFF9, 32'd2, "divu", 10);
        check("divu_lo", LO, 32'h7FFF_FFFC);
        check("divu_hi", HI, 32'd1);
        start_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 10);
        check("div_ovf_lo", LO, 32'h8000_0000);
        check("div_ovf_hi", HI, 32'd0);

        // divide by zero keeps preloaded HI/LO
        one_cycle(4'd5, 32'h11);
        one_cycle(4'd6, 32'h22);
        check("mt_busy", Busy, 0);
        start_op(4'd3, 32'd123, 32'd0, "div0", 10);
        check("div0_hi", HI, 32'h11);
        check("div0_lo", LO, 32'h22);
        read_md(4'd8, "mflo", 32'h22);
        read_md(4'd7, "mfhi", 32'h11);
        e_MDop = 4'd12;
        #1 check("op12_start", Start, 0);
        check("op12_mdout", e_MDout, 0);
        @(posedge clk); #1;

        // ops during the busy window are ignored
        e_MDop = 4'd3; e_A = 32'd100; e_B = 32'd7;
        @(posedge clk); #1;
        e_MDop = 4'd5; e_A = 32'hAA;
        #1 check("win_mthi_start", Start, 0);
        @(posedge clk); #1;
        e_MDop = 4'd1; e_A = 32'd3; e_B = 32'd3;
        #1 check("win_mult_start", Start, 0);
        @(posedge clk); #1;
        e_MDop = 4'd0;
        wait_idle("win", 8);
        check("win_hi", HI, 32'd2);
        check("win_lo", LO, 32'd14);

        // msub with a negative product: {2,0xE} - (-12)
        start_op(4'd9, 32'hFFFF_FFFD, 32'd4, "msub_neg", 5);
        check("msub_neg_hi", HI, 32'd2);
        check("msub_neg_lo", LO, 32'h1A);

        // reset abort in the third busy cycle
        e_MDop = 4'd1; e_A = 32'd5; e_B = 32'd5;
        @(posedge clk); #1;
        e_MDop = 4'd0;
        repeat (2) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1 check("abort_busy", Busy, 0);
        check("abort_hi", HI, 0);
        check("abort_lo", LO, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("abort_hi_after", HI, 0);
        check("abort_lo_after", LO, 0);
        start_op(4'd1, 32'd5, 32'd5, "post_rst", 5);
        check("post_rst_lo", LO, 32'd25);
        check("post_rst_hi", HI, 32'd0);

        // first edge after reset release accepts a start immediately
        reset = 1'b1;
        #2 reset = 1'b0;
        start_op(4'd2, 32'd7, 32'd6, "rst_then_start", 5);
        check("rst_then_start_lo", LO, 32'd42);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/e_muldiv.md
E_MULDIV -- requirements
Module: e_muldiv

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, the number of Busy cycles for mult, multu and msub.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, the number of Busy cycles for div and divu.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port e_A, input, 32 bits: forwarded rs value of the E-stage instruction.
REQ-006 SHALL have port e_B, input, 32 bits: forwarded rt value of the E-stage instruction.
REQ-007 SHALL have port e_MDop, input, 4 bits: E-stage op code. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 msub; 10-15 are treated as none.
REQ-008 SHALL have port Start, output, 1 bit: a start op is accepted this cycle; it feeds the D-stage stall unit.
REQ-009 SHALL have port Busy, output, 1 bit, registered: an operation is in flight; it feeds the D-stage stall unit.
REQ-010 SHALL have port HI, output, 32 bits: the architectural HI register.
REQ-011 SHALL have port LO, output, 32 bits: the architectural LO register.
REQ-012 SHALL have port e_MDout, output, 32 bits: the mfhi/mflo read result.

Function
REQ-013 Start SHALL be combinational: 1 when e_MDop is in {1,2,3,4,9} and Busy=0, else 0.
REQ-014 On an edge with Start=1, the block SHALL compute the 64-bit result from e_A/e_B into pending registers, load a down-counter with MUL_CYCLES or DIV_CYCLES, and set Busy=1.
REQ-015 If Start is asserted in cycle T, Busy SHALL be 1 in cycles T+1..T+N. HI/LO SHALL take the result at the edge ending cycle T+N and be visible in T+N+1, where Busy=0.
REQ-016 Arithmetic:
- mult: {HI,LO} = signed 64-bit product.
- multu: {HI,LO} = unsigned 64-bit product.
- msub: {HI,LO} = old {HI,LO} minus the signed product, where old {HI,LO} is the value at the Start edge; the result wraps mod 2^64.
REQ-017 div/divu: LO = quotient, HI = remainder. Signed div truncates toward zero and the remainder takes the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-018 Division by zero SHALL still hold Busy for DIV_CYCLES, and HI/LO SHALL be left unchanged at completion.
REQ-019 mthi/mtlo with Busy=0 SHALL write e_A into HI/LO at the next edge, with no Busy.
REQ-020 Any e_MDop arriving while Busy=1 (start, mthi, mtlo) SHALL be ignored. The stall unit guarantees this case never occurs.
REQ-021 e_MDout SHALL be combinational: HI when e_MDop=7, LO when e_MDop=8, else 0. It reflects the current HI/LO registers, with no bypass of a pending result.
REQ-022 Busy SHALL fall in the same cycle that the new HI/LO becomes visible, so a stalled mfhi released that cycle reads the new value.
REQ-023 A Start SHALL be accepted in the first cycle Busy=0 after completion, so back-to-back operations are separated by zero idle cycles.

Reset
REQ-024 While reset=1, asynchronously: HI=0, LO=0, Busy=0, counter=0, pending registers=0. Start and e_MDout follow their combinational definitions.
REQ-025 Reset mid-operation SHALL abort it: the pending result is discarded and HI/LO never receive it.
REQ-026 The first edge after reset deasserts SHALL behave as idle, so a Start is accepted immediately.

Verification
REQ-027 mult: e_A=0xFFFFFFFE, e_B=3, op=1 -> Start=1 for 1 cycle, Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-028 multu then msub:
- multu with e_A=0xFFFFFFFF, e_B=2 -> HI=1, LO=0xFFFFFFFE.
- Then msub with e_A=1, e_B=1 -> HI=1, LO=0xFFFFFFFD.
REQ-029 div and divu:
- div with e_A=-7 (0xFFFFFFF9), e_B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu on the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-030 Divide by zero: HI=0x11, LO=0x22 preloaded with mthi/mtlo, then div by 0 -> Busy for 10 cycles, then HI=0x11, LO=0x22. mflo -> e_MDout=0x22.
REQ-031 Reset abort: mult 5x5 started, reset pulsed in the 3rd Busy cycle -> Busy=0 immediately; HI=0 and LO=0 persist after reset deasserts.
REQ-032 Busy-window ops: during a div, drive mthi with e_A=0xAA and a mult -> both ignored, Start=0 throughout, final HI/LO equal the div result only.
